// File: rtl/weight_rd_responder.sv
// Responder for word read requests against a fixed-latency weight SRAM.
// Responses come back in order through a FIFO sized to cover every outstanding request.
module weight_rd_responder #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        MEM_DEPTH  = 1024,
  parameter int unsigned        RD_LAT     = 2,
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_req,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic                         req_vld,
  output logic                         req_rdy,
  output logic [ADDR_W-1:0]            rsp_addr,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_vld,
  input  logic                         rsp_rdy,
  output logic                         mem_en,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         err,
  input  logic                         err_clr,
  output logic                         busy
);

  localparam int unsigned MemAw = $clog2(MEM_DEPTH);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] MemBytes = ADDR_W'(MEM_DEPTH * 4);

  logic [CntW-1:0]   outst_q, outst_d;
  logic              accept, pop, push, bad;
  logic [ADDR_W-1:0] off;
  logic              err_q, err_d;

  logic [RD_LAT-1:0] tag_vld_q, tag_bad_q;
  logic [ADDR_W-1:0] tag_addr_q [RD_LAT];

  logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] push_data;

  // Gated by rst_n so nothing can be accepted while reset is held.
  assign req_rdy  = rst_n & req_req & (outst_q < CntW'(FIFO_DEPTH));
  assign accept   = req_req & req_vld & req_rdy;
  assign off      = req_addr - BASE_ADDR;
  assign bad      = (off[1:0] != 2'b00) | (off >= MemBytes);
  assign mem_en   = accept & ~bad;
  assign mem_addr = mem_en ? off[2 +: MemAw] : '0;

  assign push      = tag_vld_q[RD_LAT-1];
  assign push_data = tag_bad_q[RD_LAT-1] ? '0 : mem_rdata;

  assign rsp_vld  = (wr_ptr_q != rd_ptr_q);
  assign pop      = rsp_vld & rsp_rdy;
  assign rsp_addr = fifo_addr_q[rd_ptr_q[PtrW-1:0]];
  assign rsp_data = fifo_data_q[rd_ptr_q[PtrW-1:0]];

  assign err  = err_q;
  assign busy = (outst_q != '0);

  always_comb begin
    outst_d = outst_q;
    if (accept && !pop) begin
      outst_d = outst_q + 1'b1;
    end else if (pop && !accept) begin
      outst_d = outst_q - 1'b1;
    end
  end

  // A new error in the same cycle outranks the clear.
  always_comb begin
    err_d = err_q;
    if (accept && bad) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  // Tag pipeline tracks each accepted request until its SRAM data is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      tag_bad_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        tag_addr_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0]  <= accept;
      tag_bad_q[0]  <= bad;
      tag_addr_q[0] <= req_addr;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_bad_q[i]  <= tag_bad_q[i-1];
        tag_addr_q[i] <= tag_addr_q[i-1];
      end
    end
  end

  // The outstanding limit guarantees a free entry whenever push is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_addr_q[wr_ptr_q[PtrW-1:0]] <= tag_addr_q[RD_LAT-1];
        fifo_data_q[wr_ptr_q[PtrW-1:0]] <= push_data;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule
